// File: rtl/serial_compare_frame_driver.sv
// Frame driver for 1-bit serial magnitude comparators: accepts an operand pair, clears the
// comparator, shifts the bits out and returns the verdict. Optional SERIAL_CMP_SELF_CHECK_EN adds err.
module serial_compare_frame_driver #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    output logic             ser_clr,
    output logic             ser_a,
    output logic             ser_b,
    input  logic             cmp_less,
    input  logic             cmp_eq,
    input  logic             cmp_greater,
    output logic             res_valid,
    input  logic             res_ready,
    output logic             res_less,
    output logic             res_eq,
    output logic             res_greater
`ifdef SERIAL_CMP_SELF_CHECK_EN
    ,
    output logic             err
`endif
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] CLEAR  = 2'd1;
    localparam logic [1:0] SHIFT  = 2'd2;
    localparam logic [1:0] RESULT = 2'd3;

    localparam int            CW   = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    logic [1:0]       r_state;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_sh_a;
    logic [WIDTH-1:0] r_sh_b;
    logic             r_res_less;
    logic             r_res_eq;
    logic             r_res_greater;

    logic             w_bit_a;
    logic             w_bit_b;
    logic [WIDTH-1:0] w_sh_a_next;
    logic [WIDTH-1:0] w_sh_b_next;
    logic             w_capture;

    // The outgoing bit always sits at the shift-register end nearest the serial port.
    assign w_bit_a     = MSB_FIRST ? r_sh_a[WIDTH-1] : r_sh_a[0];
    assign w_bit_b     = MSB_FIRST ? r_sh_b[WIDTH-1] : r_sh_b[0];
    assign w_sh_a_next = MSB_FIRST ? {r_sh_a[WIDTH-2:0], 1'b0} : {1'b0, r_sh_a[WIDTH-1:1]};
    assign w_sh_b_next = MSB_FIRST ? {r_sh_b[WIDTH-2:0], 1'b0} : {1'b0, r_sh_b[WIDTH-1:1]};
    assign w_capture   = (r_state == SHIFT) && (r_cnt == LAST);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state       <= IDLE;
            r_cnt         <= '0;
            r_sh_a        <= '0;
            r_sh_b        <= '0;
            r_res_less    <= 1'b0;
            r_res_eq      <= 1'b0;
            r_res_greater <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_sh_a  <= in_a;
                        r_sh_b  <= in_b;
                        r_state <= CLEAR;
                    end
                end
                CLEAR: begin
                    r_cnt   <= '0;
                    r_state <= SHIFT;
                end
                SHIFT: begin
                    r_cnt  <= r_cnt + CW'(1);
                    r_sh_a <= w_sh_a_next;
                    r_sh_b <= w_sh_b_next;
                    if (w_capture) begin
                        r_res_less    <= cmp_less;
                        r_res_eq      <= cmp_eq;
                        r_res_greater <= cmp_greater;
                        r_state       <= RESULT;
                    end
                end
                default: begin
                    if (res_ready) begin
                        r_state <= IDLE;
                    end
                end
            endcase
        end
    end

    assign in_ready    = (r_state == IDLE);
    assign ser_clr     = (r_state == CLEAR);
    assign ser_a       = (r_state == SHIFT) & w_bit_a;
    assign ser_b       = (r_state == SHIFT) & w_bit_b;
    assign res_valid   = (r_state == RESULT);
    assign res_less    = r_res_less;
    assign res_eq      = r_res_eq;
    assign res_greater = r_res_greater;

`ifdef SERIAL_CMP_SELF_CHECK_EN
    // Shift registers are consumed while sending, so keep an untouched copy for the parallel check.
    logic [WIDTH-1:0] r_op_a;
    logic [WIDTH-1:0] r_op_b;
    logic             r_err;
    logic [2:0]       w_par;

    assign w_par = {r_op_a < r_op_b, r_op_a == r_op_b, r_op_a > r_op_b};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_op_a <= '0;
            r_op_b <= '0;
            r_err  <= 1'b0;
        end else begin
            if (r_state == IDLE && in_valid) begin
                r_op_a <= in_a;
                r_op_b <= in_b;
            end
            // w_par is one-hot, so any non-one-hot verdict also mismatches here.
            if (w_capture && ({cmp_less, cmp_eq, cmp_greater} != w_par)) begin
                r_err <= 1'b1;
            end
        end
    end

    assign err = r_err;
`endif

endmodule

// File: tb/tb_serial_compare_frame_driver.sv
// Directed bench: an MSB-first and an LSB-first driver, each with a behavioural serial comparator,
// fed the same operand pairs; verdicts and timing are checked against hand-computed values.
module tb_serial_compare_frame_driver;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       res_ready;
    logic       force_eq;
    logic [7:0] in_a;
    logic [7:0] in_b;

    logic in_ready1, ser_clr1, ser_a1, ser_b1, res_valid1, res_less1, res_eq1, res_gt1;
    logic in_ready2, ser_clr2, ser_a2, ser_b2, res_valid2, res_less2, res_eq2, res_gt2;
    logic c1_less, c1_eq, c1_gt, c2_less, c2_eq, c2_gt;
    logic m1_lt = 1'b0, m1_gt = 1'b0, m2_lt = 1'b0, m2_gt = 1'b0;
`ifdef SERIAL_CMP_SELF_CHECK_EN
    logic err1, err2;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    serial_compare_frame_driver #(.WIDTH(8), .MSB_FIRST(1'b1)) u_dut_msb (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready1),
        .in_a(in_a), .in_b(in_b), .ser_clr(ser_clr1), .ser_a(ser_a1), .ser_b(ser_b1),
        .cmp_less(c1_less), .cmp_eq(c1_eq), .cmp_greater(c1_gt),
        .res_valid(res_valid1), .res_ready(res_ready),
        .res_less(res_less1), .res_eq(res_eq1), .res_greater(res_gt1)
`ifdef SERIAL_CMP_SELF_CHECK_EN
        , .err(err1)
`endif
    );

    serial_compare_frame_driver #(.WIDTH(8), .MSB_FIRST(1'b0)) u_dut_lsb (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready2),
        .in_a(in_a), .in_b(in_b), .ser_clr(ser_clr2), .ser_a(ser_a2), .ser_b(ser_b2),
        .cmp_less(c2_less), .cmp_eq(c2_eq), .cmp_greater(c2_gt),
        .res_valid(res_valid2), .res_ready(res_ready),
        .res_less(res_less2), .res_eq(res_eq2), .res_greater(res_gt2)
`ifdef SERIAL_CMP_SELF_CHECK_EN
        , .err(err2)
`endif
    );

    // MSB-first comparator: the first differing bit decides and is then held.
    always_comb begin
        c1_less = m1_lt | (!m1_gt & !ser_a1 & ser_b1);
        c1_gt   = m1_gt | (!m1_lt & ser_a1 & !ser_b1);
        c1_eq   = (!c1_less & !c1_gt) | force_eq;
    end
    always @(posedge clk) begin
        if (ser_clr1) begin
            m1_lt <= 1'b0; m1_gt <= 1'b0;
        end else begin
            m1_lt <= c1_less; m1_gt <= c1_gt;
        end
    end

    // LSB-first comparator: every differing bit overrides the earlier decision.
    always_comb begin
        c2_less = (!ser_a2 & ser_b2) | (!(ser_a2 ^ ser_b2) & m2_lt);
        c2_gt   = (ser_a2 & !ser_b2) | (!(ser_a2 ^ ser_b2) & m2_gt);
        c2_eq   = (!c2_less & !c2_gt) | force_eq;
    end
    always @(posedge clk) begin
        if (ser_clr2) begin
            m2_lt <= 1'b0; m2_gt <= 1'b0;
        end else begin
            m2_lt <= c2_less; m2_gt <= c2_gt;
        end
    end

    task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present a pair, walk the frame up to the cycle res_valid must rise (T0+10).
    task automatic frame_to_result(input logic [7:0] a, input logic [7:0] b, input string tag);
        logic [7:0] sa1, sb1, sa2, sb2;
        sa1 = '0; sb1 = '0; sa2 = '0; sb2 = '0;
        in_a = a; in_b = b; in_valid = 1'b1;
        check_value({tag, ".in_ready"}, {30'd0, in_ready1, in_ready2}, 32'h3);
        tick();
        in_valid = 1'b0; in_a = ~a; in_b = ~b;
        check_value({tag, ".clear"},
                    {26'd0, ser_clr1, ser_clr2, in_ready1, in_ready2, ser_a1 | ser_b1, ser_a2 | ser_b2},
                    32'h30);
        for (int i = 0; i < 8; i++) begin
            tick();
            sa1 = {sa1[6:0], ser_a1}; sb1 = {sb1[6:0], ser_b1};
            sa2 = {ser_a2, sa2[7:1]}; sb2 = {ser_b2, sb2[7:1]};
            check_value({tag, ".shift"}, {28'd0, ser_clr1, ser_clr2, res_valid1, res_valid2}, 32'h0);
        end
        check_value({tag, ".msb_ser"}, {16'd0, sa1, sb1}, {16'd0, a, b});
        check_value({tag, ".lsb_ser"}, {16'd0, sa2, sb2}, {16'd0, a, b});
        tick();
        check_value({tag, ".res_valid"}, {30'd0, res_valid1, res_valid2}, 32'h3);
    endtask

    task automatic check_verdict(input string tag, input logic [2:0] exp);
        check_value({tag, ".msb_verdict"}, {29'd0, res_less1, res_eq1, res_gt1}, {29'd0, exp});
        check_value({tag, ".lsb_verdict"}, {29'd0, res_less2, res_eq2, res_gt2}, {29'd0, exp});
    endtask

    task automatic release_result(input string tag, input logic [2:0] exp);
        res_ready = 1'b1;
        tick();
        check_value({tag, ".release"}, {28'd0, res_valid1, res_valid2, in_ready1, in_ready2}, 32'h3);
        check_verdict({tag, ".retain"}, exp);
    endtask

    initial begin
        rst = 1'b0; in_valid = 1'b0; res_ready = 1'b1; force_eq = 1'b0;
        in_a = '0; in_b = '0;
        #2;
        check_value("reset", {in_ready1, ser_clr1, ser_a1, ser_b1, res_valid1, res_less1, res_eq1, res_gt1,
                              in_ready2, ser_clr2, ser_a2, ser_b2, res_valid2, res_less2, res_eq2, res_gt2},
                    32'h8080);
        tick(); tick();
        rst = 1'b1;
        tick();

        frame_to_result(8'h64, 8'h62, "gt");
        check_verdict("gt", 3'b001);
        release_result("gt", 3'b001);

        frame_to_result(8'h82, 8'h82, "eq");
        check_verdict("eq", 3'b010);
`ifdef SERIAL_CMP_SELF_CHECK_EN
        check_value("eq.err", {30'd0, err1, err2}, 32'h0);
`endif
        release_result("eq", 3'b010);

        // Back-pressure with a new pair waiting; it must not be taken until the verdict is consumed.
        res_ready = 1'b0;
        frame_to_result(8'h10, 8'h81, "lt");
        in_a = 8'h01; in_b = 8'h80; in_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            check_value("bp.hold", {20'd0, res_valid1, res_less1, res_eq1, res_gt1, in_ready1, ser_clr1,
                                    res_valid2, res_less2, res_eq2, res_gt2, in_ready2, ser_clr2},
                        32'hC30);
        end
        release_result("bp", 3'b100);
        frame_to_result(8'h01, 8'h80, "b2b");
        check_verdict("b2b", 3'b100);
        release_result("b2b", 3'b100);

        // Faulty comparator: eq forced high for a>b, captured verbatim.
        force_eq = 1'b1;
        frame_to_result(8'h03, 8'h01, "forced");
        check_verdict("forced", 3'b011);
`ifdef SERIAL_CMP_SELF_CHECK_EN
        check_value("forced.err", {30'd0, err1, err2}, 32'h3);
`endif
        force_eq = 1'b0;
        release_result("forced", 3'b011);

        frame_to_result(8'h40, 8'h40, "eq2");
        check_verdict("eq2", 3'b010);
`ifdef SERIAL_CMP_SELF_CHECK_EN
        check_value("eq2.err_sticky", {30'd0, err1, err2}, 32'h3);
`endif
        release_result("eq2", 3'b010);

        // Reset three cycles into SHIFT.
        in_a = 8'hF0; in_b = 8'h0F; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick(); tick(); tick();
        rst = 1'b0;
        #1;
        check_value("midrst", {in_ready1, ser_clr1, ser_a1, ser_b1, res_valid1, res_less1, res_eq1, res_gt1,
                               in_ready2, ser_clr2, ser_a2, ser_b2, res_valid2, res_less2, res_eq2, res_gt2},
                    32'h8080);
`ifdef SERIAL_CMP_SELF_CHECK_EN
        check_value("midrst.err", {30'd0, err1, err2}, 32'h0);
`endif
        tick();
        check_value("midrst.hold", {28'd0, res_valid1, res_valid2, in_ready1, in_ready2}, 32'h3);
        rst = 1'b1;
        tick();

        frame_to_result(8'h05, 8'h06, "post_rst");
        check_verdict("post_rst", 3'b100);
`ifdef SERIAL_CMP_SELF_CHECK_EN
        check_value("post_rst.err", {30'd0, err1, err2}, 32'h0);
`endif
        release_result("post_rst", 3'b100);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
